// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy count and error pulses.
module sync_fifo_flex #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr_en,
  input  logic [DATA_WIDTH-1:0]         i_din,
  input  logic                          i_rd_en,
  output logic [DATA_WIDTH-1:0]         o_dout,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_almost_full,
  output logic                          o_almost_empty,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_W      = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CNT_W-1:0]      w_count_nxt;

  assign w_wr_acc = i_wr_en & ~r_full;
  assign w_rd_acc = i_rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Flags are registered alongside count so they always reflect the stored occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty        <= (w_count_nxt == CNT_W'(0));
      r_almost_full  <= (w_count_nxt >= CNT_W'(AFULL_THRESH));
      r_almost_empty <= (w_count_nxt <= CNT_W'(AEMPTY_THRESH));
      r_overflow     <= i_wr_en & r_full;
      r_underflow    <= i_rd_en & r_empty;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_dout = r_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= r_mem[r_rd_ptr];
        end
      end
      assign o_dout = r_dout;
    end
  endgenerate

  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: three instances (standard, FWFT, tight thresholds) share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_sync_fifo_flex;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] s_dout, f_dout, t_dout;
  logic [4:0]    s_count, f_count, t_count;
  logic s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic t_full, t_empty, t_af, t_ae, t_ovf, t_unf;

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEP), .FWFT(0)) u_std (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_din(din), .i_rd_en(rd_en),
    .o_dout(s_dout), .o_full(s_full), .o_empty(s_empty), .o_almost_full(s_af),
    .o_almost_empty(s_ae), .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_unf));

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEP), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_din(din), .i_rd_en(rd_en),
    .o_dout(f_dout), .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_af),
    .o_almost_empty(f_ae), .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_unf));

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEP), .FWFT(0), .AFULL_THRESH(4),
                   .AEMPTY_THRESH(0)) u_thr (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_din(din), .i_rd_en(rd_en),
    .o_dout(t_dout), .o_full(t_full), .o_empty(t_empty), .o_almost_full(t_af),
    .o_almost_empty(t_ae), .o_count(t_count), .o_overflow(t_ovf), .o_underflow(t_unf));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: contents as a queue, plus last word popped and error pulses.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_sd  = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    logic [DW-1:0] head = (n > 0) ? q[0] : '0;
    chk("std.count",  32'(s_count), 32'(n));
    chk("std.empty",  32'(s_empty), 32'(n == 0));
    chk("std.full",   32'(s_full),  32'(n == DEP));
    chk("std.afull",  32'(s_af),    32'(n >= DEP - 2));
    chk("std.aempty", 32'(s_ae),    32'(n <= 2));
    chk("std.ovf",    32'(s_ovf),   32'(m_ovf));
    chk("std.unf",    32'(s_unf),   32'(m_unf));
    chk("std.dout",   32'(s_dout),  32'(m_sd));
    chk("fwft.count", 32'(f_count), 32'(n));
    chk("fwft.empty", 32'(f_empty), 32'(n == 0));
    chk("fwft.ovf",   32'(f_ovf),   32'(m_ovf));
    chk("fwft.unf",   32'(f_unf),   32'(m_unf));
    chk("fwft.dout",  32'(f_dout),  32'(head));
    chk("thr.afull",  32'(t_af),    32'(n >= 4));
    chk("thr.aempty", 32'(t_ae),    32'(n == 0));
    chk("thr.dout",   32'(t_dout),  32'(m_sd));
  endtask

  // One clock: drive inputs, advance the model at the edge, check just after it.
  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
    int n;
    rst = r; wr_en = w; din = d; rd_en = rd;
    @(posedge clk);
    n = q.size();
    if (r) begin
      q.delete();
      m_sd = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_ovf = w && (n == DEP);
      m_unf = rd && (n == 0);
      if (rd && n > 0) m_sd = q.pop_front();
      if (w && n < DEP) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset, with requests during reset that must be ignored.
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'hFF, 1);

    // Fill 0x00..0x0F, then overflow with 0xAA.
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'hAA, 0);
    step(0, 0, 8'h00, 0);

    // Drain, then underflow.
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Count 5, then 40 cycles of simultaneous access (pointers wrap twice).
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom), 1);

    // Full with both asserted, then empty with both asserted.
    while (q.size() < DEP) step(0, 1, 8'($urandom), 0);
    step(0, 1, 8'($urandom), 1);
    step(0, 1, 8'($urandom), 0);
    while (q.size() > 0) step(0, 0, 8'h00, 1);
    step(0, 1, 8'($urandom), 1);
    step(0, 0, 8'h00, 1);

    // FWFT fall-through of 0x3C into an empty FIFO, then pop to empty.
    step(0, 1, 8'h3C, 0);
    chk("fwft.fall_through", 32'(f_dout), 32'h3C);
    step(0, 0, 8'h00, 1);

    // Reset in the middle of a concurrent burst at count 9.
    for (int i = 0; i < 9; i++) step(0, 1, 8'($urandom), 0);
    step(0, 1, 8'($urandom), 1);
    step(1, 1, 8'($urandom), 1);
    step(0, 1, 8'h55, 0);
    step(0, 0, 8'h00, 1);
    chk("std.after_reset_55", 32'(s_dout), 32'h55);

    // Randomised traffic with drifting write/read bias and rare resets.
    for (int i = 0; i < 400; i++) begin
      bit w, rd, r;
      w  = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 127) == 0);
      step(r, w, 8'($urandom), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Single-clock, parametrised FIFO; successor to the dual-clock Gray-pointer FIFO for paths where both sides share one clock. Adds:
- selectable standard or first-word-fall-through (FWFT) read mode;
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- overflow and underflow error pulses.

It sits between a producer and a consumer in the same clock domain.

## Interface

- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 16, capacity in words; must be a power of two ≥2; ADDR_WIDTH = $clog2(DEPTH)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-2, almost_full asserts when count ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this value (0..DEPTH-1)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- wr_en  input  1  write request
- din  input  DATA_WIDTH  write data
- rd_en  input  1  read request (FWFT: acknowledge of the head word)
- dout  output  DATA_WIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AFULL_THRESH
- almost_empty  output  1  count ≤ AEMPTY_THRESH
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: a write was rejected
- underflow  output  1  one-cycle pulse: a read was rejected

## Operation

- State:
  - wr_ptr and rd_ptr, ADDR_WIDTH bits each; they wrap naturally modulo DEPTH.
  - count register, ADDR_WIDTH+1 bits.
  - DEPTH × DATA_WIDTH memory.
- Flags full, empty, almost_full and almost_empty are combinational functions of the registered count only. They are never derived from the current-cycle wr_en/rd_en.
- Write accepted = wr_en & ~full. On acceptance: mem[wr_ptr] ← din; wr_ptr +1.
- Read accepted = rd_en & ~empty. On acceptance: rd_ptr +1.
- count update:
  - +1 on write-only accept;
  - −1 on read-only accept;
  - unchanged when both or neither are accepted.
- Simultaneous wr_en & rd_en:
  - 0 < count < DEPTH: both accepted; count unchanged.
  - Full: read accepted, write rejected, overflow pulses.
  - Empty: write accepted, read rejected, underflow pulses.
- Standard mode (FWFT=0):
  - dout is a register, loaded with mem[rd_ptr] on an accepted read.
  - Otherwise dout holds its value; it holds the last read word indefinitely.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally when ~empty; dout = 0 when empty.
  - rd_en pops the displayed word; the next word is presented the cycle after the edge.
- overflow is a registered pulse: 1 in the cycle after an edge where wr_en & full. underflow is the same for rd_en & empty. Each is high for exactly one cycle per rejected request and does not stick.
- Rejected requests change no pointer, count or memory location.
- Reset (any time, including mid-burst):
  - clears wr_ptr, rd_ptr, count, dout, overflow and underflow;
  - memory contents are not cleared;
  - wr_en and rd_en in the reset cycle are ignored.
- Reset values:
  - dout = 0, count = 0, empty = 1, full = 0;
  - almost_empty = 1;
  - almost_full = 0, since AFULL_THRESH ≥ 1;
  - overflow = 0, underflow = 0.

## Timing

- Write to visibility: a word accepted at edge N updates count and flags after edge N. In FWFT, a write into an empty FIFO at edge N drives dout with that word after edge N.
- Standard read latency: rd_en sampled at edge N; the word appears on dout after edge N.
- FWFT read latency: 0. The word is valid whenever empty = 0.
- Throughput: one write and one read per cycle, sustained.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Full-to-not-full transition: a read accepted at edge N deasserts full after edge N. A write offered in the cycle after N is accepted.

## Test plan

- **Reset/fill/drain:** DEPTH=16, FWFT=0.
  - After reset: empty=1, almost_empty=1, count=0, dout=0.
  - Write 0x00..0x0F on consecutive cycles: full=1 and count=16 after the 16th edge; almost_full=1 from count=14.
  - Read 16 words: dout sequence 0x00..0x0F, one cycle after each rd_en; empty=1 at the end.
- **Overflow/underflow:**
  - When full, write 0xAA: overflow=1 for one cycle; count stays 16; the later drain never shows 0xAA.
  - When empty, assert rd_en: underflow=1 for one cycle; dout unchanged.
- **Simultaneous access:**
  - At count=5, wr_en and rd_en together for 40 cycles: count stays 5; data out is in order; pointers wrap twice with no loss.
  - When full with both asserted: one read, write rejected, overflow=1.
  - When empty with both asserted: one write accepted, underflow=1.
- **FWFT=1:**
  - Write 0x3C into an empty FIFO: dout=0x3C and empty=0 after that edge, with no rd_en.
  - rd_en: dout shows the next word (or 0 if empty) after the edge.
- **Mid-operation reset:**
  - At count=9 during a concurrent write burst, pulse rst for one cycle: count=0, empty=1, dout=0, overflow/underflow=0.
  - A subsequent write/read of 0x55 returns 0x55.
- **Threshold parameters:** AFULL_THRESH=4, AEMPTY_THRESH=0.
  - almost_full rises exactly at count 4 and falls at 3.
  - almost_empty is high only at count 0.
